// File: rtl/addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_seq
//  Brief    : Multi-cycle saturating add/subtract; one CHUNK-bit slice per
//             cycle with a rippled carry register and valid/ready handshakes.
//  Revision : 1.0
// ============================================================================
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovfl,
    output logic             sat,
    output logic             zero,
    output logic             neg,
    output logic             cout
);

    localparam int c_num_slices = WIDTH / CHUNK;
    localparam int c_cnt_w      = (c_num_slices > 1) ? $clog2(c_num_slices) : 1;
    localparam logic [c_cnt_w-1:0] c_last_slice = c_cnt_w'(c_num_slices - 1);
    localparam logic [WIDTH-1:0]   c_max_pos    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   c_min_neg    = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;        // already inverted for subtract
    logic               r_sat_en;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;

    logic [CHUNK:0]     w_slice;
    logic [WIDTH-1:0]   w_sum_next;
    logic               w_pos_ov;
    logic               w_neg_ov;
    logic [WIDTH-1:0]   w_res;

    always_comb begin
        w_slice    = {1'b0, r_a[r_cnt*CHUNK +: CHUNK]}
                   + {1'b0, r_b[r_cnt*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, r_carry};
        w_sum_next = r_sum;
        w_sum_next[r_cnt*CHUNK +: CHUNK] = w_slice[CHUNK-1:0];
        // Only meaningful on the edge that completes the MSB slice.
        w_pos_ov   = ~r_a[WIDTH-1] & ~r_b[WIDTH-1] &  w_sum_next[WIDTH-1];
        w_neg_ov   =  r_a[WIDTH-1] &  r_b[WIDTH-1] & ~w_sum_next[WIDTH-1];
        if (r_sat_en && w_pos_ov)
            w_res = c_max_pos;
        else if (r_sat_en && w_neg_ov)
            w_res = c_min_neg;
        else
            w_res = w_sum_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            ovfl      <= 1'b0;
            sat       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            cout      <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_sat_en  <= 1'b0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_sum     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= sub ? ~b : b;
                        r_sat_en <= sat_en;
                        r_carry  <= sub;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        r_state  <= c_st_calc;
                    end
                end
                c_st_calc: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_slice[CHUNK];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_last_slice) begin
                        result    <= w_res;
                        ovfl      <= w_pos_ov | w_neg_ov;
                        sat       <= r_sat_en & (w_pos_ov | w_neg_ov);
                        zero      <= (w_res == '0);
                        neg       <= w_res[WIDTH-1];
                        cout      <= w_slice[CHUNK];
                        out_valid <= 1'b1;
                        r_state   <= c_st_done;
                    end
                end
                c_st_done: begin
                    // in_ready rises only after the handshake edge, so no
                    // back-to-back accept on the same edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= c_st_idle;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_addsub_seq
//  Brief    : Self-checking bench for addsub_seq (16/4, 8/2 and 32/8 builds).
//  Revision : 1.0
// ============================================================================
module tb_addsub_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, sub, sat_en, out_valid, out_ready;
    logic [15:0] a, b, result;
    logic        ovfl, sat, zero, neg, cout;

    logic        in_valid8, in_ready8, out_valid8, ovfl8, sat8, zero8, neg8, cout8;
    logic [7:0]  a8, b8, result8;
    logic        in_valid32, in_ready32, out_valid32, ovfl32, sat32, zero32, neg32, cout32;
    logic [31:0] a32, b32, result32;

    addsub_seq #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .ovfl(ovfl), .sat(sat), .zero(zero), .neg(neg), .cout(cout)
    );

    addsub_seq #(.WIDTH(8), .CHUNK(2)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(1'b0), .sat_en(1'b1),
        .out_valid(out_valid8), .out_ready(1'b1), .result(result8),
        .ovfl(ovfl8), .sat(sat8), .zero(zero8), .neg(neg8), .cout(cout8)
    );

    addsub_seq #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .sub(1'b0), .sat_en(1'b1),
        .out_valid(out_valid32), .out_ready(1'b1), .result(result32),
        .ovfl(ovfl32), .sat(sat32), .zero(zero32), .neg(neg32), .cout(cout32)
    );

    typedef struct packed {
        logic [15:0] res;
        logic        ovfl, sat, zero, neg, cout;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;
    int   lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Integer-domain reference: exact signed result, then clamp.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic s, input logic se);
        int   sx = $signed(x);
        int   sy = $signed(y);
        int   v  = s ? (sx - sy) : (sx + sy);
        exp_t e;
        e.ovfl = (v > 32767) || (v < -32768);
        e.sat  = e.ovfl && se;
        if (se && v > 32767)       e.res = 16'h7FFF;
        else if (se && v < -32768) e.res = 16'h8000;
        else                       e.res = v[15:0];
        e.zero = (e.res == 16'h0000);
        e.neg  = e.res[15];
        e.cout = s ? (x >= y) : (({1'b0, x} + {1'b0, y}) > 17'h0FFFF);
        return e;
    endfunction

    // Drive one operation through the accept edge; returns at the next negedge.
    task automatic start(input logic [15:0] x, input logic [15:0] y,
                         input logic s, input logic se);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = x; b = y; sub = s; sat_en = se; in_valid = 1'b1;
        sb.push_back(model(x, y, s, se));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = ~s; sat_en = ~se;
        check("in_ready_calc", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_result(input int exp_lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("out_valid", 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            cur = sb.pop_front();
            check("result", 32'(result), 32'(cur.res));
            check("flags", {27'd0, ovfl, sat, zero, neg, cout},
                  {27'd0, cur.ovfl, cur.sat, cur.zero, cur.neg, cur.cout});
        end
        check("in_ready_done", 32'(in_ready), 32'd0);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; sat_en = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0;
        in_valid32 = 1'b0; a32 = '0; b32 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", {10'd0, result, ovfl, sat, zero, neg, cout}, 32'd0);

        // Directed cases from the plan, then a few random ones
        start(16'h1234, 16'h0F0F, 1'b0, 1'b1); wait_result(4); handshake();
        check("plain_add", 32'(cur.res), 32'h2143);
        start(16'h7FFF, 16'h0001, 1'b0, 1'b1); wait_result(4); handshake();
        start(16'h7FFF, 16'h0001, 1'b0, 1'b0); wait_result(4); handshake();
        start(16'h8000, 16'h0001, 1'b1, 1'b1); wait_result(4); handshake();
        start(16'h0000, 16'h8000, 1'b1, 1'b1); wait_result(4); handshake();
        check("sub_minneg", 32'(result), 32'h7FFF);
        start(16'h0005, 16'h0005, 1'b1, 1'b1); wait_result(4); handshake();
        check("sub_zero", {30'd0, zero, cout}, 32'd3);
        for (int i = 0; i < 6; i++) begin
            start(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            wait_result(4);
            handshake();
        end

        // Input toggling in CALC, stalled output in DONE
        start(16'h4000, 16'h4000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            in_valid = ~in_valid; a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
        end
        wait_result(1);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid; a = 16'($urandom); sub = ~sub;
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'(result), 32'(cur.res));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        handshake();
        repeat (6) @(negedge clk);
        check("no_spurious", 32'(out_valid), 32'd0);

        // Reset two cycles after accept aborts the operation
        start(16'h1111, 16'h2222, 1'b0, 1'b0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_outputs", {10'd0, result, ovfl, sat, zero, neg, cout}, 32'd0);
        repeat (6) @(negedge clk);
        check("abort_no_valid", 32'(out_valid), 32'd0);
        start(16'h0001, 16'h0001, 1'b0, 1'b0); wait_result(4); handshake();
        check("post_abort", 32'(cur.res), 32'h0002);

        // Other parameterisations
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01; in_valid8 = 1'b1;
        a32 = 32'h7FFF_FFFF; b32 = 32'h1; in_valid32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0; in_valid32 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("w8_latency", 32'(lat), 32'd4);
        check("w8_result", 32'(result8), 32'h7F);
        check("w8_flags", {30'd0, ovfl8, sat8}, 32'd3);
        check("w32_valid", 32'(out_valid32), 32'd1);
        check("w32_result", result32, 32'h7FFF_FFFF);
        check("w32_sat", 32'(sat32), 32'd1);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
Parametrised, multi-cycle saturating adder/subtractor for the ALU datapath. Processes a WIDTH-bit two's-complement add or subtract one CHUNK-bit slice per cycle, rippling the carry through an internal register. Uses a valid/ready handshake on both input and output. Adds optional saturation, a raw overflow flag, zero/negative flags, and carry-out for flag-register updates.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK and at least 2.
CHUNK, 4, slice width processed per cycle; N = WIDTH/CHUNK slices.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operands and mode valid.
in_ready  out  1  block can accept an operation.
a  in  WIDTH  operand A, two's complement.
b  in  WIDTH  operand B, two's complement.
sub  in  1  1 = A-B, 0 = A+B.
sat_en  in  1  1 = clamp result on overflow, 0 = wrap.
out_valid  out  1  result and flags valid.
out_ready  in  1  consumer accepts result.
result  out  WIDTH  final sum/difference.
ovfl  out  1  signed overflow occurred, independent of sat_en.
sat  out  1  result was clamped (ovfl & sat_en).
zero  out  1  result == 0 (after clamping).
neg  out  1  result[WIDTH-1].
cout  out  1  carry out of the MSB slice, unsaturated.

Behaviour:
- Reset is synchronous and active-high: clock is clk, reset is rst; polarity and synchronicity are fixed.
- rst=1 at an edge forces the following, and overrides every other event:
  - state=IDLE, in_ready=1, out_valid=0.
  - result, ovfl, sat, zero, neg and cout all 0.
  - Internal slice counter and carry register cleared.
- FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the block captures a, b_eff (= sub ? ~b : b), sat_en, and carry=sub.
  - Counter is set to 0; next state is CALC.
- CALC:
  - in_ready=0 and in_valid is ignored.
  - Each edge adds slice [counter*CHUNK +: CHUNK] of A and b_eff plus the carry register, writes that slice of the internal sum, updates carry, and increments counter.
  - On the edge that processes slice N-1:
    - Overflow is computed as pos = ~A[MSB] & ~b_eff[MSB] & sum[MSB]; neg_ov = A[MSB] & b_eff[MSB] & ~sum[MSB].
    - ovfl = pos | neg_ov.
    - result = (sat_en & pos) ? max positive (0111..1) : (sat_en & neg_ov) ? min negative (1000..0) : sum.
    - sat = sat_en & ovfl; zero and neg are derived from result; cout = final carry.
    - Next state is DONE.
- Latency:
  - The accept edge is k; out_valid goes high after edge k+N.
  - Throughput is one operation per N+2 cycles at best.
- DONE:
  - out_valid=1; result and flags are held stable until the handshake.
  - On an edge with out_ready=1, out_valid drops and next state is IDLE.
  - A new operation cannot be accepted on that same edge; in_ready rises the cycle after.
- Outputs:
  - result and flags retain their last value after the handshake until the next completion or reset.
  - During CALC the visible result is unchanged.
- Subtracting the minimum negative value is handled by the ~b + carry-in form. For example, 0 - 0x8000 with sat_en=1 gives ovfl=1 and result 0x7FFF.
- Operands and mode are registered at accept, so input changes during CALC/DONE have no effect.
- Reset asserted mid-CALC or in DONE aborts the operation; out_valid never asserts for the aborted operation.

Test Plan:
1. WIDTH=16, CHUNK=4: a=0x1234, b=0x0F0F, sub=0, sat_en=1, out_ready=1 -> out_valid 4 cycles after accept; result=0x2143; ovfl=0, sat=0, zero=0, neg=0, cout=0.
2. Positive saturation: a=0x7FFF, b=0x0001, add, sat_en=1 -> result=0x7FFF, ovfl=1, sat=1. Same operands with sat_en=0 -> result=0x8000, ovfl=1, sat=0, neg=1.
3. Negative saturation and sub edge:
   - a=0x8000, b=0x0001, sub=1, sat_en=1 -> result=0x8000, ovfl=1, sat=1.
   - a=0x0000, b=0x8000, sub=1 -> result=0x7FFF, sat=1.
   - a=0x0005, b=0x0005, sub=1 -> result=0x0000, zero=1, cout=1.
4. Handshake:
   - Hold out_ready=0 for 5 cycles in DONE -> out_valid and result stable, in_ready=0.
   - Toggle in_valid with new operands during CALC/DONE -> ignored.
   - Raise out_ready -> in_ready=1 on the following cycle.
5. Reset mid-operation: assert rst 2 cycles after accept -> next cycle state IDLE, in_ready=1, out_valid=0, all outputs 0. The next operation a=0x0001, b=0x0001 returns 0x0002 with correct latency.
6. Parametrisation: WIDTH=8, CHUNK=2 -> a=0x7F, b=0x01, add, sat_en=1 gives 0x7F with sat=1 after 4 cycles. WIDTH=32, CHUNK=8 -> 0x7FFFFFFF+1 with sat_en=1 gives 0x7FFFFFFF.
